// File: rtl/auto_nav_controller.sv
// Autonomous navigation FSM: drives forward, debounces the front detector and
// requests left/right turns (or a two-turn U-turn) from the turn executor.
module auto_nav_controller #(
  parameter int CNT_W           = 12,
  parameter int DEBOUNCE_MS     = 20,
  parameter int SETTLE_MS       = 200,
  parameter int TURN_TIMEOUT_MS = 1500,
  parameter int PREFER_RIGHT    = 0
) (
  input  logic       clk_ms,
  input  logic       rst,
  input  logic       auto_enable,
  input  logic       det_front,
  input  logic       det_left,
  input  logic       det_right,
  input  logic       finish_turning,
  output logic [3:0] state,
  output logic       left_right,
  output logic       move_forward,
  output logic       fault
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0000,
    FORWARD = 4'b0100,
    DECIDE  = 4'b0101,
    SETTLE  = 4'b0110,
    TURN    = 4'b0111,
    STOP    = 4'b1001
  } nav_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_MS - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_TIMEOUT_MS - 1);
  localparam logic             PREF_DIR    = (PREFER_RIGHT != 0);

  nav_state_t       cur_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       turns_rem;
  logic             pref_blocked;
  logic             other_blocked;

  assign state         = cur_state;
  assign pref_blocked  = PREF_DIR ? det_right : det_left;
  assign other_blocked = PREF_DIR ? det_left  : det_right;

  // Every output is updated together with the state it belongs to, so the
  // executor never sees a state/direction pair from two different cycles.
  always_ff @(posedge clk_ms) begin
    if (rst || !auto_enable) begin
      cur_state    <= IDLE;
      cnt          <= '0;
      turns_rem    <= 2'd0;
      left_right   <= 1'b0;
      move_forward <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (cur_state)
        IDLE: begin
          cur_state    <= FORWARD;
          cnt          <= '0;
          left_right   <= 1'b0;
          move_forward <= 1'b1;
          fault        <= 1'b0;
        end

        FORWARD: begin
          if (!det_front) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt          <= '0;
            cur_state    <= DECIDE;
            move_forward <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Both sides blocked means a dead end: two turns the same way.
        DECIDE: begin
          cnt       <= '0;
          cur_state <= TURN;
          if (!pref_blocked) begin
            left_right <= PREF_DIR;
            turns_rem  <= 2'd1;
          end else if (!other_blocked) begin
            left_right <= ~PREF_DIR;
            turns_rem  <= 2'd1;
          end else begin
            left_right <= PREF_DIR;
            turns_rem  <= 2'd2;
          end
        end

        TURN: begin
          if (finish_turning) begin
            turns_rem <= turns_rem - 2'd1;
            cnt       <= '0;
            cur_state <= SETTLE;
          end else if (cnt == TURN_LAST) begin
            cnt       <= '0;
            cur_state <= STOP;
            fault     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (turns_rem != 2'd0) begin
              cur_state <= TURN;
            end else begin
              cur_state    <= FORWARD;
              move_forward <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        STOP: begin
          move_forward <= 1'b0;
          fault        <= 1'b1;
        end

        default: begin
          cur_state    <= IDLE;
          cnt          <= '0;
          turns_rem    <= 2'd0;
          left_right   <= 1'b0;
          move_forward <= 1'b0;
          fault        <= 1'b0;
        end
      endcase
    end
  end

endmodule
